sram_axi_arbiter: RTL and testbench
===================================

# sram_axi_arbiter

Bridges the CPU's two SRAM-like ports (instruction fetch and data access from the EXE/MEM stages) onto one AXI3 master port. The inst port is read-only; the data port issues reads and writes. Each requester gets at most one outstanding transaction, and the block arbitrates the shared AR channel between them. It sits between the pipeline core and the top-level AXI interconnect.

## Interface
- No parameters. Widths are fixed: 32-bit address and data, 4-bit ID.
- clk  in  1  clock; the single clock for the block.
- reset  in  1  synchronous, active-high.
- inst_sram_req / inst_sram_addr  in  1 / 32  instruction read request and its address. Size is always 2 (word).
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok / inst_sram_rdata  out  1 / 32  read-data return.
- data_sram_req, data_sram_wr  in  1, 1  data request; wr=1 means a write.
- data_sram_size / data_sram_wstrb  in  2 / 4  access size and byte enables.
- data_sram_addr / data_sram_wdata  in  32 / 32  address and write data.
- data_sram_addr_ok, data_sram_data_ok  out  1, 1  accept and complete (read or write).
- data_sram_rdata  out  32  read data.
- AXI read channels:
  - arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1  out; arready 1  in.
  - rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in; rready 1  out.
- AXI write channels:
  - awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out (same widths as AR); awready  in.
  - wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1  out; wready  in.
  - bid 4, bresp 2, bvalid 1  in; bready 1  out.

## Operation
- Constant AXI fields:
  - arlen/awlen = 0, arburst/awburst = 2'b01, lock/cache/prot = 0, wlast = 1.
  - IDs: inst reads use ID 0; data reads, awid, and wid use ID 1.
  - arsize/awsize = {1'b0, size}.
- The block keeps one pending flag per requester: inst_pend and data_pend.
  - Set on addr_ok.
  - Cleared on that requester's data_ok.
- AR FSM has two states, AR_IDLE and AR_BUSY.
  - In AR_IDLE, inst is eligible when inst_sram_req & ~inst_pend.
  - In AR_IDLE, data is eligible when data_sram_req & ~data_sram_wr & ~data_pend & W FSM in W_IDLE.
  - The winner gets a combinational addr_ok. Addr and ID are registered, and the FSM moves to AR_BUSY.
  - In AR_BUSY, arvalid=1 and all fields are held stable. On arready the FSM returns to AR_IDLE.
- Read return: rready is always 1.
  - On an rvalid handshake, rdata is latched into the rdata register of the requester selected by rid[0].
  - That requester's data_ok pulses for exactly one cycle, in the next cycle.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE → W_REQ: on data_sram_req & wr & ~data_pend & AR FSM not granting data this cycle. addr_ok is given, and addr, wdata and wstrb are latched.
  - In W_REQ, awvalid and wvalid are each dropped independently on their own handshake. The FSM moves to W_RESP once both have completed, including when both complete in the same cycle.
  - In W_RESP, bready=1. On bvalid, data_sram_data_ok pulses in the next cycle and the FSM returns to W_IDLE.
- A data write and a data read are never accepted in the same cycle (single request line).
- Every handshake uses valid-before-ready: a valid is never withdrawn before its ready.
- Reset values:
  - All valid outputs 0, data_ok 0, rdata registers 0.
  - FSMs in AR_IDLE/W_IDLE, pend flags 0.
  - rready=1 and bready=0 (bready is 0 outside W_RESP).
- Reset during an operation discards all state immediately. The AXI slave is reset in the same cycle.

## Timing
- Read latency:
  - req+addr_ok in cycle T → arvalid in T+1.
  - With arready in T+1 and rvalid in T+2 (earliest), data_ok and rdata are presented in T+3.
- A write in cycle T gives awvalid/wvalid in T+1. With zero-wait slave handshakes, data_ok comes 1 cycle after bvalid.
- addr_ok is combinational from req and internal state, with no registered delay.
- Reads are in order per requester. inst and data responses may overtake each other.
- inst and data data_ok may be asserted in the same cycle.

## Configuration
- SRAM_AXI_RR_EN defined:
  - When inst and data are both eligible in AR_IDLE, grant round-robin.
  - A 1-bit last-grant register flips after each contested grant. Its reset value favours data first.
- Undefined: data always wins, with fixed priority.

## Structure
- Shared package `sram_axi_pkg`:
  - AR and W state encodings.
  - ID constants INST_ID=4'd0 and DATA_ID=4'd1.
  - AXI burst/len constants.
- One sub-module: `sram_axi_rd_arb`. It contains eligibility logic, the grant (with optional round-robin), and the AR register.
- The write FSM and read-return logic live in the top module.

## Test plan
- Inst read of 0x1c000000. Slave: arready immediately, rdata=0x02800400 two cycles later. Expect inst data_ok one cycle after rvalid, rdata matches, arid=0.
- Inst and data reads in the same cycle with AR free:
  - Macro off: data granted (arid=1), inst addr_ok=0, inst granted in the next AR_IDLE.
  - Macro on: a second contested pair alternates the winner.
- Data write: addr 0x1000, wdata 0xdeadbeef, wstrb 4'b0011. Slave gives awready 2 cycles before wready. Expect awvalid to drop first, wvalid to hold, then bready; data_ok one cycle after bvalid.
- Data read arriving during W_REQ/W_RESP → data addr_ok=0 until the write's data_ok cycle, then accepted.
- Out-of-order return: inst read then data read outstanding; slave returns rid=1 first. Expect data data_ok first, then inst, with correct rdata routing.
- Reset asserted in W_RESP → next cycle all valids 0, FSMs idle, no data_ok issued.

Source files
------------

// File: rtl/sram_axi_pkg.sv
// Shared encodings and AXI constants for the SRAM-to-AXI3 bridge.
// Used by sram_axi_rd_arb and sram_axi_arbiter.
package sram_axi_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  localparam logic [3:0] INST_ID        = 4'd0;
  localparam logic [3:0] DATA_ID        = 4'd1;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] INST_SIZE      = 2'd2;

  // SRAM size (bytes = 2^size) maps directly onto the AXI size field.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_rd_arb.sv
// Read-address arbiter: picks inst or data for the shared AR channel and holds
// the AR fields until accepted. Round-robin when SRAM_AXI_RR_EN is defined.
module sram_axi_rd_arb
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  input  logic        i_inst_pend,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic        i_data_pend,
  input  logic        i_w_idle,
  input  logic        i_arready,
  output logic        o_inst_grant,
  output logic        o_data_grant,
  output logic        o_arvalid,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [2:0]  o_arsize
);

  ar_state_t   r_state;
  ar_state_t   w_state_nxt;
  logic        w_inst_elig;
  logic        w_data_elig;
  logic        w_pick_data;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;

  assign w_inst_elig = (r_state == AR_IDLE) & i_inst_req & ~i_inst_pend;
  assign w_data_elig = (r_state == AR_IDLE) & i_data_req & ~i_data_wr & ~i_data_pend & i_w_idle;

`ifdef SRAM_AXI_RR_EN
  // r_inst_turn=0 after reset, so the first contested grant goes to data.
  logic r_inst_turn;
  assign w_pick_data = w_data_elig & ~(w_inst_elig & r_inst_turn);

  always_ff @(posedge clk) begin
    if (reset)                         r_inst_turn <= 1'b0;
    else if (w_inst_elig & w_data_elig) r_inst_turn <= ~r_inst_turn;
  end
`else
  assign w_pick_data = w_data_elig;
`endif

  // NOTE: state and datapath flops use non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) r_state <= AR_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this always_comb latch-free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AR_IDLE: if (w_inst_elig | w_data_elig) w_state_nxt = AR_BUSY;
      AR_BUSY: if (i_arready)                 w_state_nxt = AR_IDLE;
      default:                                w_state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    o_data_grant = w_pick_data;
    o_inst_grant = w_inst_elig & ~w_pick_data;
    o_arvalid    = (r_state == AR_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_arid   <= 4'd0;
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
    end else if (w_pick_data) begin
      r_arid   <= DATA_ID;
      r_araddr <= i_data_addr;
      r_arsize <= axi_size(i_data_size);
    end else if (w_inst_elig) begin
      r_arid   <= INST_ID;
      r_araddr <= i_inst_addr;
      r_arsize <= axi_size(INST_SIZE);
    end
  end

  assign o_arid   = r_arid;
  assign o_araddr = r_araddr;
  assign o_arsize = r_arsize;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Bridges the inst (read-only) and data SRAM-like ports onto one AXI3 master.
// Optional round-robin AR arbitration: define SRAM_AXI_RR_EN.
module sram_axi_arbiter
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  w_state_t    r_w_state;
  w_state_t    w_w_state_nxt;
  logic        r_inst_pend;
  logic        r_data_pend;
  logic        w_inst_grant;
  logic        w_data_grant;
  logic        w_wr_accept;
  logic        w_aw_done;
  logic        w_w_done;
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_inst_rd_ok;
  logic        r_data_rd_ok;
  logic        r_data_wr_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  // Only single-beat transfers with matching IDs are issued, so the
  // response/last/bid fields carry no extra information here.
  logic w_unused;
  assign w_unused = ^{rresp, rlast, rid[3:1], bid, bresp};

  sram_axi_rd_arb u_rd_arb (
    .clk         (clk),
    .reset       (reset),
    .i_inst_req  (inst_sram_req),
    .i_inst_addr (inst_sram_addr),
    .i_inst_pend (r_inst_pend),
    .i_data_req  (data_sram_req),
    .i_data_wr   (data_sram_wr),
    .i_data_size (data_sram_size),
    .i_data_addr (data_sram_addr),
    .i_data_pend (r_data_pend),
    .i_w_idle    (r_w_state == W_IDLE),
    .i_arready   (arready),
    .o_inst_grant(w_inst_grant),
    .o_data_grant(w_data_grant),
    .o_arvalid   (arvalid),
    .o_arid      (arid),
    .o_araddr    (araddr),
    .o_arsize    (arsize)
  );

  assign w_wr_accept = (r_w_state == W_IDLE) & data_sram_req & data_sram_wr
                     & ~r_data_pend & ~w_data_grant;

  assign inst_sram_addr_ok = w_inst_grant;
  assign data_sram_addr_ok = w_data_grant | w_wr_accept;
  assign inst_sram_data_ok = r_inst_rd_ok;
  assign data_sram_data_ok = r_data_rd_ok | r_data_wr_ok;
  assign inst_sram_rdata   = r_inst_rdata;
  assign data_sram_rdata   = r_data_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_pend <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      if (inst_sram_addr_ok)      r_inst_pend <= 1'b1;
      else if (inst_sram_data_ok) r_inst_pend <= 1'b0;
      if (data_sram_addr_ok)      r_data_pend <= 1'b1;
      else if (data_sram_data_ok) r_data_pend <= 1'b0;
    end
  end

  // Write FSM: AW and W complete independently; both must finish before B.
  assign w_aw_done = ~r_awvalid | awready;
  assign w_w_done  = ~r_wvalid  | wready;

  always_ff @(posedge clk) begin
    if (reset) r_w_state <= W_IDLE;
    else       r_w_state <= w_w_state_nxt;
  end

  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_wr_accept)          w_w_state_nxt = W_REQ;
      W_REQ:   if (w_aw_done & w_w_done) w_w_state_nxt = W_RESP;
      W_RESP:  if (bvalid)               w_w_state_nxt = W_IDLE;
      default:                           w_w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    bready = (r_w_state == W_RESP);
    rready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_awaddr     <= 32'd0;
      r_awsize     <= 3'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_data_wr_ok <= 1'b0;
    end else begin
      r_data_wr_ok <= (r_w_state == W_RESP) & bvalid;
      if (w_wr_accept) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= data_sram_addr;
        r_awsize  <= axi_size(data_sram_size);
        r_wdata   <= data_sram_wdata;
        r_wstrb   <= data_sram_wstrb;
      end else begin
        if (awready) r_awvalid <= 1'b0;
        if (wready)  r_wvalid  <= 1'b0;
      end
    end
  end

  // Read return: rid[0] selects the requester; data_ok follows one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_rd_ok <= 1'b0;
      r_data_rd_ok <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
    end else begin
      r_inst_rd_ok <= rvalid & ~rid[0];
      r_data_rd_ok <= rvalid &  rid[0];
      if (rvalid & ~rid[0]) r_inst_rdata <= rdata;
      if (rvalid &  rid[0]) r_data_rdata <= rdata;
    end
  end

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = r_awsize;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = r_awvalid;

  assign wid     = DATA_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter; the slave side is driven cycle by cycle.
// Contested-grant expectations follow SRAM_AXI_RR_EN.
module tb_sram_axi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_err = 0;

  sram_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic exp_data_wins;

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    tick(); tick();
    settle();
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, wvalid},  32'd0);
    check("rst_rready",  {31'd0, rready},  32'd1);
    check("rst_bready",  {31'd0, bready},  32'd0);
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
    check("const_arburst", {30'd0, arburst}, 32'd1);
    check("const_wlast", {31'd0, wlast}, 32'd1);

    // Inst read of 0x1c000000, arready immediately, rvalid next cycle.
    tick(); reset = 1'b0;
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
    settle();
    check("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 0; arready = 1; settle();
    check("t1_arvalid", {31'd0, arvalid}, 32'd1);
    check("t1_arid", {28'd0, arid}, 32'd0);
    check("t1_araddr", araddr, 32'h1c00_0000);
    check("t1_arsize", {29'd0, arsize}, 32'd2);
    tick(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0280_0400; settle();
    check("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
    check("t1_no_early_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    tick(); rvalid = 0; settle();
    check("t1_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("t1_inst_rdata", inst_sram_rdata, 32'h0280_0400);
    tick(); settle();
    check("t1_data_ok_pulse", {31'd0, inst_sram_data_ok}, 32'd0);

    // Contested AR: first contest goes to data in both builds.
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 32'h2000;
    settle();
    check("t2_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    check("t2_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick(); data_sram_req = 0; arready = 1; settle();
    check("t2_arid_data", {28'd0, arid}, 32'd1);
    check("t2_araddr_data", araddr, 32'h2000);
    check("t2_inst_blocked_busy", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick(); arready = 0; settle();
    check("t2_inst_granted_later", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 0; arready = 1; settle();
    check("t2_arid_inst", {28'd0, arid}, 32'd0);
    check("t2_araddr_inst", araddr, 32'h1c00_0010);
    tick(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h1111_1111;
    tick(); rid = 4'd0; rdata = 32'h2222_2222; settle();
    check("t2_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    check("t2_data_rdata", data_sram_rdata, 32'h1111_1111);
    tick(); rvalid = 0; settle();
    check("t2_inst_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("t2_inst_rdata", inst_sram_rdata, 32'h2222_2222);

    // Second contested pair: round-robin flips to inst, fixed priority keeps data.
`ifdef SRAM_AXI_RR_EN
    exp_data_wins = 1'b0;
`else
    exp_data_wins = 1'b1;
`endif
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040;
    data_sram_req = 1; data_sram_addr = 32'h2040;
    settle();
    check("t2b_data_addr_ok", {31'd0, data_sram_addr_ok}, {31'd0, exp_data_wins});
    check("t2b_inst_addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, ~exp_data_wins});
    tick();
    if (exp_data_wins) data_sram_req = 0; else inst_sram_req = 0;
    arready = 1;
    tick(); arready = 0; settle();
    check("t2b_loser_granted", {31'd0, data_sram_addr_ok | inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 0; data_sram_req = 0; arready = 1;
    tick(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h0;
    tick(); rid = 4'd0;
    tick(); rvalid = 0;
    tick();

    // Write with awready two cycles ahead of wready; a read waits behind it.
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2;
    data_sram_addr = 32'h1000; data_sram_wdata = 32'hdead_beef; data_sram_wstrb = 4'b0011;
    settle();
    check("t3_wr_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    tick(); data_sram_wr = 0; data_sram_addr = 32'h3000; awready = 1; settle();
    check("t3_awvalid", {31'd0, awvalid}, 32'd1);
    check("t3_wvalid", {31'd0, wvalid}, 32'd1);
    check("t3_awaddr", awaddr, 32'h1000);
    check("t3_wdata", wdata, 32'hdead_beef);
    check("t3_wstrb", {28'd0, wstrb}, 32'h3);
    check("t3_awid", {28'd0, awid}, 32'd1);
    check("t4_rd_blocked_wreq", {31'd0, data_sram_addr_ok}, 32'd0);
    tick(); awready = 0; settle();
    check("t3_awvalid_drop", {31'd0, awvalid}, 32'd0);
    check("t3_wvalid_hold", {31'd0, wvalid}, 32'd1);
    check("t3_bready_low", {31'd0, bready}, 32'd0);
    tick(); wready = 1; settle();
    check("t3_wvalid_hold2", {31'd0, wvalid}, 32'd1);
    tick(); wready = 0; settle();
    check("t3_wvalid_drop", {31'd0, wvalid}, 32'd0);
    check("t3_bready", {31'd0, bready}, 32'd1);
    check("t4_rd_blocked_wresp", {31'd0, data_sram_addr_ok}, 32'd0);
    tick(); bvalid = 1; settle();
    check("t3_no_early_ok", {31'd0, data_sram_data_ok}, 32'd0);
    tick(); bvalid = 0; settle();
    check("t3_wr_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    check("t3_bready_drop", {31'd0, bready}, 32'd0);
    check("t4_rd_blocked_okcyc", {31'd0, data_sram_addr_ok}, 32'd0);
    tick(); settle();
    check("t4_rd_accepted", {31'd0, data_sram_addr_ok}, 32'd1);
    check("t3_data_ok_pulse", {31'd0, data_sram_data_ok}, 32'd0);
    tick(); data_sram_req = 0; arready = 1; settle();
    check("t4_araddr", araddr, 32'h3000);
    tick(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h3333_3333;
    tick(); rvalid = 0; settle();
    check("t4_rdata", data_sram_rdata, 32'h3333_3333);

    // Out-of-order return: inst issued first, data response comes back first.
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0020; settle();
    check("t5_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h4000; arready = 1; settle();
    check("t5_data_blocked_busy", {31'd0, data_sram_addr_ok}, 32'd0);
    tick(); arready = 0; settle();
    check("t5_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    tick(); data_sram_req = 0; arready = 1;
    tick(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h4444_4444;
    tick(); rid = 4'd0; rdata = 32'h5555_5555; settle();
    check("t5_data_ok_first", {31'd0, data_sram_data_ok}, 32'd1);
    check("t5_inst_not_yet", {31'd0, inst_sram_data_ok}, 32'd0);
    check("t5_data_rdata", data_sram_rdata, 32'h4444_4444);
    tick(); rvalid = 0; settle();
    check("t5_inst_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("t5_inst_rdata", inst_sram_rdata, 32'h5555_5555);
    check("t5_data_rdata_kept", data_sram_rdata, 32'h4444_4444);

    // Simultaneous AW/W completion, then reset while waiting in W_RESP.
    tick();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h5000; settle();
    check("t6_wr_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    tick(); data_sram_req = 0; data_sram_wr = 0; awready = 1; wready = 1;
    tick(); awready = 0; wready = 0; settle();
    check("t6_both_done", {30'd0, awvalid, wvalid}, 32'd0);
    check("t6_wresp", {31'd0, bready}, 32'd1);
    tick(); reset = 1; bvalid = 1;
    tick(); reset = 0; bvalid = 0;
    data_sram_req = 1; data_sram_addr = 32'h6000; settle();
    check("t6_rst_bready", {31'd0, bready}, 32'd0);
    check("t6_rst_no_ok", {31'd0, data_sram_data_ok}, 32'd0);
    check("t6_rst_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
    check("t6_rst_idle_accept", {31'd0, data_sram_addr_ok}, 32'd1);
    tick(); data_sram_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
